// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, credit-limited imem requests, in-order {pc,instr} FIFO toward decode, redirect flush.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect yields a single trap entry).
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instr,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        fetch_misalign,
`endif
    output logic [1:0]  dbg_state_o
);
    // Handshakes: a transfer happens on a posedge where valid && ready; once imem_req_valid is
    // high its address holds until accepted (redirect excepted). imem responses have no ready.
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
`ifdef FETCH_MISALIGN_TRAP_EN
        TRAP   = 2'd3,
`endif
        HALTED = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rpc_wr_q, rpc_rd_q;
    logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]   fifo_instr_q [FIFO_DEPTH];
    logic [31:0]   rpc_q        [FIFO_DEPTH];
`ifdef FETCH_MISALIGN_TRAP_EN
    logic          fifo_mis_q   [FIFO_DEPTH];
    logic          mis_redirect;
    assign mis_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif

    logic [CW:0] occupancy;
    logic        accept, rsp_drop, push, pop;

    // Stale requests still hold credit until their response returns.
    assign occupancy      = (CW+1)'(count_q) + (CW+1)'(inflight_q);
    assign imem_req_valid = (state_q == RUN) && !redirect_valid && !halt && (occupancy < DEPTH_C);
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_drop       = imem_rsp_valid && (drop_q != '0);
    assign push           = imem_rsp_valid && !rsp_drop && !redirect_valid;
    assign fetch_valid    = (count_q != '0);
    assign pop            = fetch_valid && fetch_ready && !redirect_valid;
    assign fetch_pc       = fetch_valid ? fifo_pc_q[rd_ptr_q] : 32'd0;
    assign fetch_instr    = fetch_valid ? fifo_instr_q[rd_ptr_q] : 32'd0;
    assign dbg_state_o    = state_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_misalign = fetch_valid && fifo_mis_q[rd_ptr_q];
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = accept ? pc_q + 32'd4 : pc_q;
        inflight_d = inflight_q + CW'(accept) - CW'(imem_rsp_valid);
        drop_d     = drop_q - CW'(rsp_drop);
        count_d    = count_q + CW'(push) - CW'(pop);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt && inflight_q == '0) state_d = HALTED;
            HALTED:  if (!halt) state_d = RUN;
            default: state_d = state_q;
        endcase
        if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the old path.
            state_d  = halt ? HALTED : RUN;
            pc_d     = redirect_pc & ~32'd3;
            drop_d   = inflight_d;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (mis_redirect) begin
                state_d  = TRAP;
                count_d  = CW'(1);
                wr_ptr_d = PW'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rpc_wr_q   <= '0;
            rpc_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rpc_wr_q   <= rpc_wr_q + PW'(accept);
            rpc_rd_q   <= rpc_rd_q + PW'(imem_rsp_valid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
                rpc_q[i]        <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
                fifo_mis_q[i]   <= 1'b0;
`endif
            end
        end else begin
            if (accept) rpc_q[rpc_wr_q] <= pc_q;
            if (push) begin
                fifo_pc_q[wr_ptr_q]    <= rpc_q[rpc_rd_q];
                fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
`ifdef FETCH_MISALIGN_TRAP_EN
                fifo_mis_q[wr_ptr_q]   <= 1'b0;
`endif
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            if (mis_redirect) begin
                fifo_pc_q[0]    <= redirect_pc;
                fifo_instr_q[0] <= 32'h0000_0013;
                fifo_mis_q[0]   <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model, program-order stream reference, directed and random phases.
module tb_instr_fetch_unit;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fetch_valid, fetch_ready;
    logic [31:0] fetch_pc, fetch_instr;
    logic [1:0]  dbg_state;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    instr_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_misalign(fetch_misalign),
`endif
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } mreq_t;

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_pc0;
        logic [31:0] exp_pc1;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1, rdy_pct = 100;
    int          fetch_cnt = 0;
    mreq_t       mq[$];
    logic [31:0] acc_log[$];
    logic [31:0] fetch_log[$];
    logic [31:0] exp_req_pc, exp_fetch_pc;
    bit          trap_mode = 0, trap_pending = 0;
    logic [31:0] trap_pc = '0;
    vec_t        vecs[$];

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] acc_at(int i);
        return (i < acc_log.size()) ? acc_log[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] fetch_at(int i);
        return (i < fetch_log.size()) ? fetch_log[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive memory, sample at negedge+1, update the reference, advance.
    task automatic cycle();
        bit rsp_fire;
        int rdy;
        rsp_fire       = (mq.size() > 0) && (mq[0].rdy <= cyc);
        imem_rsp_valid = rsp_fire;
        imem_rsp_data  = rsp_fire ? mem_word(mq[0].addr) : $urandom;
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        #1;
        if (redirect_valid) check("req_valid_on_redirect", {31'd0, imem_req_valid}, 32'd0);
        else if (imem_req_valid) check("req_addr", imem_req_addr, exp_req_pc);
        if (halt) check("req_valid_while_halt", {31'd0, imem_req_valid}, 32'd0);
        if (trap_mode && !redirect_valid) check("req_valid_in_trap", {31'd0, imem_req_valid}, 32'd0);
        if (imem_req_valid && imem_req_ready) begin
            rdy = cyc + $urandom_range(lat_max, lat_min);
            if (mq.size() > 0 && rdy <= mq[$].rdy) rdy = mq[$].rdy + 1;
            mq.push_back('{addr: imem_req_addr, rdy: rdy});
            acc_log.push_back(imem_req_addr);
            exp_req_pc = exp_req_pc + 32'd4;
            check("outstanding_le_depth", {31'd0, mq.size() <= DEPTH}, 32'd1);
        end
        if (rsp_fire) void'(mq.pop_front());
        if (fetch_valid && fetch_ready && !redirect_valid) begin
            fetch_log.push_back(fetch_pc);
            fetch_cnt++;
            if (trap_pending) begin
                check("trap_pc", fetch_pc, trap_pc);
                check("trap_instr", fetch_instr, 32'h0000_0013);
`ifdef FETCH_MISALIGN_TRAP_EN
                check("trap_misalign", {31'd0, fetch_misalign}, 32'd1);
`endif
                trap_pending = 0;
            end else begin
                check("fetch_pc", fetch_pc, exp_fetch_pc);
                check("fetch_instr", fetch_instr, mem_word(exp_fetch_pc));
`ifdef FETCH_MISALIGN_TRAP_EN
                check("fetch_misalign_clear", {31'd0, fetch_misalign}, 32'd0);
`endif
                exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
        end
        if (redirect_valid) begin
            exp_req_pc   = redirect_pc & ~32'd3;
            exp_fetch_pc = redirect_pc & ~32'd3;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_mode    = (redirect_pc[1:0] != 2'b00);
            trap_pending = trap_mode;
            trap_pc      = redirect_pc;
`endif
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_redirect(logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        cycle();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_fetches(int n, int budget, string name);
        int k;
        k = 0;
        while (fetch_log.size() < n && k < budget) begin
            cycle();
            k++;
        end
        check({name, "_in_time"}, {31'd0, fetch_log.size() >= n}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{target: 32'h0000_0200, exp_pc0: 32'h0000_0200, exp_pc1: 32'h0000_0204});
        vecs.push_back('{target: 32'hFFFF_FFFC, exp_pc0: 32'hFFFF_FFFC, exp_pc1: 32'h0000_0000});
        vecs.push_back('{target: 32'h8000_0000, exp_pc0: 32'h8000_0000, exp_pc1: 32'h8000_0004});
        vecs.push_back('{target: 32'h0000_7FF8, exp_pc0: 32'h0000_7FF8, exp_pc1: 32'h0000_7FFC});
`ifndef FETCH_MISALIGN_TRAP_EN
        vecs.push_back('{target: 32'h0000_1002, exp_pc0: 32'h0000_1000, exp_pc1: 32'h0000_1004});
`endif

        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; fetch_ready = 1'b1;
        exp_req_pc = RST_PC; exp_fetch_pc = RST_PC;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_fetch_pc", fetch_pc, 32'd0);
        check("rst_fetch_instr", fetch_instr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("boot_no_req", {31'd0, imem_req_valid}, 32'd0);

        // Streaming from reset
        repeat (20) cycle();
        check("s1_addr0", acc_at(0), 32'h100);
        check("s1_addr1", acc_at(1), 32'h104);
        check("s1_addr2", acc_at(2), 32'h108);
        check("s1_fetch0", fetch_at(0), 32'h100);
        check("s1_fetch1", fetch_at(1), 32'h104);
        check("s1_progress", {31'd0, fetch_log.size() >= 8}, 32'd1);

        // Decode stalled: exactly DEPTH requests, then credit exhausted
        fetch_ready = 1'b0;
        do_redirect(32'h100);
        acc_log.delete();
        repeat (10) cycle();
        #1;
        check("s2_accepts", acc_log.size(), DEPTH);
        check("s2_req_idle", {31'd0, imem_req_valid}, 32'd0);
        check("s2_head_valid", {31'd0, fetch_valid}, 32'd1);
        check("s2_head_pc", fetch_pc, 32'h100);
        fetch_ready = 1'b1;
        fetch_log.delete();
        repeat (10) cycle();
        check("s2_order0", fetch_at(0), 32'h100);
        check("s2_order1", fetch_at(1), 32'h104);

        // Redirect with two requests in flight
        lat_min = 4; lat_max = 4;
        for (int k = 0; k < 20 && mq.size() != 2; k++) cycle();
        check("s3_two_inflight", mq.size(), 2);
        do_redirect(32'h200);
        fetch_log.delete();
        wait_fetches(1, 30, "s3");
        check("s3_first_pc", fetch_at(0), 32'h200);

        // Redirect coinciding with a response, after an accept the cycle before
        lat_min = 2; lat_max = 2;
        for (int k = 0; k < 40 && !(mq.size() == 2 && mq[0].rdy == cyc); k++) cycle();
        check("s4_setup", {31'd0, mq.size() == 2 && mq[0].rdy == cyc}, 32'd1);
        do_redirect(32'h300);
        fetch_log.delete();
        wait_fetches(1, 30, "s4");
        check("s4_first_pc", fetch_at(0), 32'h300);

        // Halt with one request in flight
        lat_min = 3; lat_max = 3;
        halt = 1'b1;
        repeat (10) cycle();
        halt = 1'b0;
        do_redirect(32'h400);
        cycle();
        check("s5_one_inflight", mq.size(), 1);
        halt = 1'b1;
        fetch_log.delete();
        acc_log.delete();
        repeat (8) cycle();
        check("s5_drained_count", fetch_log.size(), 1);
        check("s5_drained_pc", fetch_at(0), 32'h400);
        check("s5_no_requests", acc_log.size(), 0);
        halt = 1'b0;
        repeat (6) cycle();
        check("s5_resume_pc", acc_at(0), 32'h404);

        // Table of redirect targets
        foreach (vecs[v]) begin
            lat_min = 1; lat_max = 3;
            do_redirect(vecs[v].target);
            fetch_log.delete();
            wait_fetches(2, 40, "vec");
            check($sformatf("vec%0d_pc0", v), fetch_at(0), vecs[v].exp_pc0);
            check($sformatf("vec%0d_pc1", v), fetch_at(1), vecs[v].exp_pc1);
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        fetch_ready = 1'b0;
        do_redirect(32'h202);
        acc_log.delete();
        repeat (5) cycle();
        #1;
        check("trap_head_valid", {31'd0, fetch_valid}, 32'd1);
        check("trap_head_pc", fetch_pc, 32'h202);
        check("trap_head_instr", fetch_instr, 32'h13);
        check("trap_head_flag", {31'd0, fetch_misalign}, 32'd1);
        fetch_ready = 1'b1;
        repeat (6) cycle();
        check("trap_no_requests", acc_log.size(), 0);
        check("trap_fifo_empty", {31'd0, fetch_valid}, 32'd0);
        do_redirect(32'h300);
        repeat (6) cycle();
        check("trap_exit_pc", acc_at(0), 32'h300);
`endif

        // Random traffic against the program-order reference
        lat_min = 1; lat_max = 4; rdy_pct = 70;
        fetch_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            fetch_ready    = ($urandom_range(99) < 75);
            halt           = halt ? ($urandom_range(99) < 85) : ($urandom_range(99) < 3);
            redirect_valid = ($urandom_range(99) < 3);
`ifdef FETCH_MISALIGN_TRAP_EN
            redirect_pc    = $urandom & ~32'd3;
`else
            redirect_pc    = $urandom;
`endif
            cycle();
        end
        redirect_valid = 1'b0;
        halt = 1'b0;
        check("rand_progress", {31'd0, fetch_cnt > 100}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
